// File: rtl/iz_param_frame_loader.sv
// ----------------------------------------------------------------------------
// iz_param_frame_loader
//
// Upstream stage of the Izhikevich neuron. Parameter frames arrive one byte per
// valid cycle and are assembled into the four 16-bit neuron parameters
// (a, b, c, d). Each frame carries an XOR checksum. The new set is committed
// atomically only when the checksum matches. params_ready is held low while a
// frame is in flight, so the neuron freezes during a load.
//
// Frame: SYNC, a_lo, a_hi, b_lo, b_hi, c_lo, c_hi, d_lo, d_hi, CHK
//        CHK = XOR of the 8 data bytes
//
// Ports
//   clk           in   1   clock
//   reset         in   1   synchronous, active-high
//   cfg_valid     in   1   cfg_byte valid this cycle (one byte per high cycle)
//   cfg_byte      in   8   frame byte
//   param_a..d    out  16  committed parameters
//   params_ready  out  1   committed set valid and no frame in progress
//   load_busy     out  1   frame in progress
//   load_error    out  1   sticky; last frame failed (checksum or timeout)
//   frame_count   out  8   good frames committed, wraps 255->0
// ----------------------------------------------------------------------------
module iz_param_frame_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [15:0] DEFAULT_A      = 16'h0001,
    parameter logic [15:0] DEFAULT_B      = 16'h000D,
    parameter logic [15:0] DEFAULT_C      = 16'hEFC0,
    parameter logic [15:0] DEFAULT_D      = 16'h0200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_valid,
    input  logic [7:0]  cfg_byte,
    output logic [15:0] param_a,
    output logic [15:0] param_b,
    output logic [15:0] param_c,
    output logic [15:0] param_d,
    output logic        params_ready,
    output logic        load_busy,
    output logic        load_error,
    output logic [7:0]  frame_count
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Shadow holds the 8 data bytes, byte 0 in bits [7:0] (a_lo).
    logic [63:0]        shadow;
    logic [2:0]         idx;
    logic [7:0]         chk_run;
    logic [TIMER_W-1:0] timer;
    // Remembers whether any frame has ever committed, so a failed frame can
    // restore params_ready to its pre-frame value.
    logic               committed;

    logic start;
    logic take_data;
    logic commit;
    logic fail;
    logic tick;

    // Next-state and per-cycle action decode. A byte on the terminal timer
    // cycle is accepted; the abort only fires when no byte arrives.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        take_data  = 1'b0;
        commit     = 1'b0;
        fail       = 1'b0;
        tick       = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_valid && cfg_byte == SYNC_BYTE) begin
                    start      = 1'b1;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (cfg_valid) begin
                    take_data = 1'b1;
                    if (idx == 3'd7) begin
                        state_next = CHECK;
                    end
                end else if (timer == TIMER_LAST) begin
                    fail       = 1'b1;
                    state_next = IDLE;
                end else begin
                    tick = 1'b1;
                end
            end
            CHECK: begin
                if (cfg_valid) begin
                    if (cfg_byte == chk_run) begin
                        commit = 1'b1;
                    end else begin
                        fail = 1'b1;
                    end
                    state_next = IDLE;
                end else if (timer == TIMER_LAST) begin
                    fail       = 1'b1;
                    state_next = IDLE;
                end else begin
                    tick = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            shadow       <= '0;
            idx          <= '0;
            chk_run      <= '0;
            timer        <= '0;
            committed    <= 1'b0;
            param_a      <= DEFAULT_A;
            param_b      <= DEFAULT_B;
            param_c      <= DEFAULT_C;
            param_d      <= DEFAULT_D;
            params_ready <= 1'b0;
            load_busy    <= 1'b0;
            load_error   <= 1'b0;
            frame_count  <= '0;
        end else begin
            state <= state_next;

            if (start) begin
                idx          <= '0;
                chk_run      <= '0;
                timer        <= '0;
                load_busy    <= 1'b1;
                params_ready <= 1'b0;
                load_error   <= 1'b0;
            end

            if (take_data) begin
                shadow[{idx, 3'b000} +: 8] <= cfg_byte;
                chk_run                    <= chk_run ^ cfg_byte;
                idx                        <= idx + 3'd1;
                timer                      <= '0;
            end

            if (tick) begin
                timer <= timer + TIMER_W'(1);
            end

            // All four parameters load on the same edge, so no mixed set is
            // ever visible downstream.
            if (commit) begin
                param_a      <= shadow[15:0];
                param_b      <= shadow[31:16];
                param_c      <= shadow[47:32];
                param_d      <= shadow[63:48];
                params_ready <= 1'b1;
                frame_count  <= frame_count + 8'd1;
                committed    <= 1'b1;
                load_busy    <= 1'b0;
                timer        <= '0;
            end

            if (fail) begin
                load_error   <= 1'b1;
                params_ready <= committed;
                load_busy    <= 1'b0;
                timer        <= '0;
            end
        end
    end

endmodule

// File: tb/tb_iz_param_frame_loader.sv
// ----------------------------------------------------------------------------
// tb_iz_param_frame_loader
//
// Directed bench for iz_param_frame_loader. Inputs change on the falling edge
// and are sampled by the DUT on the next rising edge. Outputs are checked on
// the falling edge, half a cycle after the rising edge that produced them.
// ----------------------------------------------------------------------------
module tb_iz_param_frame_loader;

    logic        clk;
    logic        reset;
    logic        cfg_valid;
    logic [7:0]  cfg_byte;
    logic [15:0] param_a;
    logic [15:0] param_b;
    logic [15:0] param_c;
    logic [15:0] param_d;
    logic        params_ready;
    logic        load_busy;
    logic        load_error;
    logic [7:0]  frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    iz_param_frame_loader dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_byte     (cfg_byte),
        .param_a      (param_a),
        .param_b      (param_b),
        .param_c      (param_c),
        .param_d      (param_d),
        .params_ready (params_ready),
        .load_busy    (load_busy),
        .load_error   (load_error),
        .frame_count  (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus: set at the falling edge, consumed at the next
    // rising edge. When this returns, the previous cycle's byte has been
    // sampled and its effect is visible on the outputs.
    task automatic applyStimulus(input logic valid, input logic [7:0] data);
        @(negedge clk);
        cfg_valid = valid;
        cfg_byte  = data;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'h00);
        end
    endtask

    // Sends the 8 data bytes (byte 0 = bits [7:0] = a_lo) followed by chk.
    task automatic sendPayload(input logic [63:0] payload, input logic [7:0] chk);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, payload[i*8 +: 8]);
        end
        applyStimulus(1'b1, chk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkParams(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input logic [15:0] d);
        checkOutput({tag, "_a"}, {16'h0, param_a}, {16'h0, a});
        checkOutput({tag, "_b"}, {16'h0, param_b}, {16'h0, b});
        checkOutput({tag, "_c"}, {16'h0, param_c}, {16'h0, c});
        checkOutput({tag, "_d"}, {16'h0, param_d}, {16'h0, d});
    endtask

    task automatic checkFlags(input string tag, input logic ready, input logic busy,
                              input logic err, input logic [7:0] count);
        checkOutput({tag, "_ready"}, {31'h0, params_ready}, {31'h0, ready});
        checkOutput({tag, "_busy"},  {31'h0, load_busy},    {31'h0, busy});
        checkOutput({tag, "_error"}, {31'h0, load_error},   {31'h0, err});
        checkOutput({tag, "_count"}, {24'h0, frame_count},  {24'h0, count});
    endtask

    // Payload a=0002 b=000D c=EFC0 d=0100; its XOR checksum is 0x21.
    localparam logic [63:0] PAY_1 = 64'h0100_EFC0_000D_0002;
    localparam logic [7:0]  CHK_1 = 8'h21;
    // Payload a=01A5 b=0002 c=1234 d=00A5 (two data bytes equal SYNC);
    // checksum A5^01^02^00^34^12^A5^00 = 0x25.
    localparam logic [63:0] PAY_2 = 64'h00A5_1234_0002_01A5;
    localparam logic [7:0]  CHK_2 = 8'h25;

    initial begin
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_byte  = 8'h00;

        // Reset then idle.
        idleCycles(2);
        reset = 1'b0;
        idleCycles(10);
        checkParams("reset", 16'h0001, 16'h000D, 16'hEFC0, 16'h0200);
        checkFlags("reset", 1'b0, 1'b0, 1'b0, 8'd0);

        // Bad frame before any commit: ready must stay low.
        applyStimulus(1'b1, 8'hA5);
        sendPayload(PAY_1, 8'h00);
        applyStimulus(1'b0, 8'h00);
        checkParams("bad_first", 16'h0001, 16'h000D, 16'hEFC0, 16'h0200);
        checkFlags("bad_first", 1'b0, 1'b0, 1'b1, 8'd0);

        // Good frame; SYNC clears the error and raises busy.
        applyStimulus(1'b1, 8'hA5);
        applyStimulus(1'b1, PAY_1[7:0]);
        checkFlags("sync", 1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b1, PAY_1[i*8 +: 8]);
        end
        applyStimulus(1'b1, CHK_1);
        checkOutput("pre_commit_a", {16'h0, param_a}, 32'h0001);
        applyStimulus(1'b0, 8'h00);
        checkParams("good1", 16'h0002, 16'h000D, 16'hEFC0, 16'h0100);
        checkFlags("good1", 1'b1, 1'b0, 1'b0, 8'd1);

        // Checksum mismatch after a commit.
        applyStimulus(1'b1, 8'hA5);
        sendPayload(PAY_1, 8'h00);
        applyStimulus(1'b0, 8'h00);
        checkParams("bad_chk", 16'h0002, 16'h000D, 16'hEFC0, 16'h0100);
        checkFlags("bad_chk", 1'b1, 1'b0, 1'b1, 8'd1);

        // Timeout: SYNC + 3 data bytes then silence.
        applyStimulus(1'b1, 8'hA5);
        applyStimulus(1'b1, 8'h02);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h0D);
        idleCycles(1024);
        checkOutput("tmo_before_busy", {31'h0, load_busy}, 32'h1);
        checkOutput("tmo_before_ready", {31'h0, params_ready}, 32'h0);
        idleCycles(1);
        checkParams("tmo", 16'h0002, 16'h000D, 16'hEFC0, 16'h0100);
        checkFlags("tmo", 1'b1, 1'b0, 1'b1, 8'd1);

        // Non-SYNC bytes in IDLE are ignored.
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'hFF);
        applyStimulus(1'b1, 8'h12);
        applyStimulus(1'b0, 8'h00);
        checkFlags("ignored", 1'b1, 1'b0, 1'b1, 8'd1);

        // SYNC-valued data bytes inside a frame are plain data.
        applyStimulus(1'b1, 8'hA5);
        sendPayload(PAY_2, CHK_2);
        applyStimulus(1'b0, 8'h00);
        checkParams("sync_data", 16'h01A5, 16'h0002, 16'h1234, 16'h00A5);
        checkFlags("sync_data", 1'b1, 1'b0, 1'b0, 8'd2);

        // Reset during byte 5 of a frame.
        applyStimulus(1'b1, 8'hA5);
        applyStimulus(1'b1, 8'h02);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h0D);
        applyStimulus(1'b1, 8'h00);
        @(negedge clk);
        reset     = 1'b1;
        cfg_valid = 1'b1;
        cfg_byte  = 8'hC0;
        applyStimulus(1'b0, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        checkParams("mid_reset", 16'h0001, 16'h000D, 16'hEFC0, 16'h0200);
        checkFlags("mid_reset", 1'b0, 1'b0, 1'b0, 8'd0);

        // Good frame after reset, with a byte arriving on the terminal
        // timer cycle (1023 idle cycles after SYNC): the byte wins.
        applyStimulus(1'b1, 8'hA5);
        idleCycles(1023);
        applyStimulus(1'b1, PAY_1[7:0]);
        applyStimulus(1'b1, PAY_1[15:8]);
        checkFlags("terminal_byte", 1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 2; i < 8; i++) begin
            applyStimulus(1'b1, PAY_1[i*8 +: 8]);
        end
        applyStimulus(1'b1, CHK_1);
        applyStimulus(1'b0, 8'h00);
        checkParams("after_reset", 16'h0002, 16'h000D, 16'hEFC0, 16'h0100);
        checkFlags("after_reset", 1'b1, 1'b0, 1'b0, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
